// File: rtl/dcache_req_ctrl.sv
// dcache_req_ctrl: CPU-side initiator of the DMEM request/response protocol.
// Accepts one memory op at a time from the pipeline and drives the DMEM request channel.
// Retries nacked requests. Discards killed ops. Returns exactly one response (data, exception
// or error) for each op that survives.
//
// Optional feature macro: DCACHE_REQ_TIMEOUT_EN adds a wait-cycle timeout (TIMEOUT_CYC).
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_*_i / req_ready_o      pipeline op handshake (ready only while idle)
//   req_kill_i                 flush of the in-flight op
//   resp_*_o                   one-cycle response pulse with data / exception bits / error
//   dmem_req_*_o, ready_i      DMEM request channel, payload held stable while valid
//   dmem_req_kill_o            kill for the last accepted request
//   dmem_resp_*_i, xcpt_*_i    DMEM response, nack and exception inputs
//   dmem_ordered_i             all prior DMEM ops complete (used by fences)
module dcache_req_ctrl #(
    parameter int unsigned ADDR_W   = 40,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned MAX_NACK = 15
`ifdef DCACHE_REQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [4:0]        req_cmd_i,
    input  logic [2:0]        req_typ_i,
    input  logic              req_kill_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic [3:0]        resp_xcpt_o,
    output logic              resp_err_o,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic [ADDR_W-1:0] dmem_req_addr_o,
    output logic [4:0]        dmem_req_cmd_o,
    output logic [2:0]        dmem_req_typ_o,
    output logic [DATA_W-1:0] dmem_req_data_o,
    output logic [TAG_W-1:0]  dmem_req_tag_o,
    output logic              dmem_req_kill_o,
    input  logic              dmem_resp_valid_i,
    input  logic [TAG_W-1:0]  dmem_resp_tag_i,
    input  logic [DATA_W-1:0] dmem_resp_data_i,
    input  logic              dmem_resp_nack_i,
    input  logic              dmem_resp_replay_i,
    input  logic              dmem_xcpt_ma_st_i,
    input  logic              dmem_xcpt_ma_ld_i,
    input  logic              dmem_xcpt_pf_st_i,
    input  logic              dmem_xcpt_pf_ld_i,
    input  logic              dmem_ordered_i
);

    localparam logic [4:0] CmdXwr   = 5'b00001;  // plain store: no load data returned
    localparam logic [4:0] CmdFence = 5'b10100;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StFence} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [4:0]          cmd_q;
    logic [2:0]          typ_q;
    logic [TAG_W-1:0]    tag_q;
    logic [TAG_W-1:0]    wait_tag_q;
    logic [3:0]          nack_cnt_q;
    logic                kill_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [3:0]          resp_xcpt_q;
    logic                resp_err_q;

    logic [3:0] xcpt_vec;
    logic       xcpt_any;
    logic       resp_hit;
    logic       to_expired;

    assign xcpt_vec = {dmem_xcpt_ma_st_i, dmem_xcpt_ma_ld_i, dmem_xcpt_pf_st_i, dmem_xcpt_pf_ld_i};
    assign xcpt_any = |xcpt_vec;
    // A replayed response always has valid set as well, so OR-ing it in changes nothing.
    assign resp_hit = (dmem_resp_valid_i || dmem_resp_replay_i) && (dmem_resp_tag_i == wait_tag_q);

`ifdef DCACHE_REQ_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
    logic [ToW-1:0] to_cnt_q;
    assign to_expired = (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
`else
    assign to_expired = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            cmd_q        <= '0;
            typ_q        <= '0;
            tag_q        <= '0;
            wait_tag_q   <= '0;
            nack_cnt_q   <= '0;
            kill_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_xcpt_q  <= '0;
            resp_err_q   <= 1'b0;
`ifdef DCACHE_REQ_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_xcpt_q  <= '0;
            resp_err_q   <= 1'b0;
            kill_q       <= 1'b0;
`ifdef DCACHE_REQ_TIMEOUT_EN
            // Idle/Req clear the counter so every waiting state is entered from zero.
            if (state_q == StIdle || state_q == StReq) to_cnt_q <= '0;
            else                                       to_cnt_q <= to_cnt_q + 1'b1;
`endif
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        addr_q     <= req_addr_i;
                        wdata_q    <= req_wdata_i;
                        cmd_q      <= req_cmd_i;
                        typ_q      <= req_typ_i;
                        nack_cnt_q <= '0;
                        state_q    <= (req_cmd_i == CmdFence) ? StFence : StReq;
                    end
                end
                StReq: begin
                    if (dmem_req_ready_i) begin
                        wait_tag_q <= tag_q;
                        tag_q      <= tag_q + 1'b1;
                        if (req_kill_i) begin
                            kill_q  <= 1'b1;
                            state_q <= StDrain;
                        end else begin
                            state_q <= StWait;
                        end
                    end else if (req_kill_i) begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (req_kill_i) begin
                        kill_q  <= 1'b1;
                        // If the op completes in the kill cycle there is nothing left to drain.
                        state_q <= (xcpt_any || dmem_resp_nack_i || resp_hit) ? StIdle : StDrain;
`ifdef DCACHE_REQ_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end else if (xcpt_any) begin
                        resp_valid_q <= 1'b1;
                        resp_xcpt_q  <= xcpt_vec;
                        state_q      <= StIdle;
                    end else if (dmem_resp_nack_i) begin
                        nack_cnt_q <= nack_cnt_q + 4'd1;
                        if (nack_cnt_q == 4'(MAX_NACK)) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            state_q <= StReq;
                        end
                    end else if (resp_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= (cmd_q == CmdXwr) ? '0 : dmem_resp_data_i;
                        nack_cnt_q   <= '0;
                        state_q      <= StIdle;
                    end else if (to_expired) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                StDrain: begin
                    if (xcpt_any || dmem_resp_nack_i || resp_hit || to_expired) state_q <= StIdle;
                end
                StFence: begin
                    if (req_kill_i) begin
                        state_q <= StIdle;
                    end else if (dmem_ordered_i) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= StIdle;
                    end else if (to_expired) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o      = (state_q == StIdle);
    assign dmem_req_valid_o = (state_q == StReq);
    assign dmem_req_addr_o  = addr_q;
    assign dmem_req_cmd_o   = cmd_q;
    assign dmem_req_typ_o   = typ_q;
    assign dmem_req_data_o  = wdata_q;
    assign dmem_req_tag_o   = tag_q;
    assign dmem_req_kill_o  = kill_q;
    assign resp_valid_o     = resp_valid_q;
    assign resp_data_o      = resp_data_q;
    assign resp_xcpt_o      = resp_xcpt_q;
    assign resp_err_o       = resp_err_q;

endmodule

// File: tb/tb_dcache_req_ctrl.sv
// tb_dcache_req_ctrl: directed testbench for dcache_req_ctrl (default configuration).
module tb_dcache_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [39:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [4:0]  req_cmd = '0;
    logic [2:0]  req_typ = '0;
    logic        req_kill = 1'b0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [3:0]  resp_xcpt;
    logic        resp_err;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic [39:0] d_addr;
    logic [4:0]  d_cmd;
    logic [2:0]  d_typ;
    logic [63:0] d_data;
    logic [7:0]  d_tag;
    logic        d_kill;
    logic        r_valid = 1'b0;
    logic [7:0]  r_tag = '0;
    logic [63:0] r_data = '0;
    logic        r_nack = 1'b0;
    logic        r_replay = 1'b0;
    logic        x_ma_st = 1'b0;
    logic        x_ma_ld = 1'b0;
    logic        x_pf_st = 1'b0;
    logic        x_pf_ld = 1'b0;
    logic        ordered = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    dcache_req_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_addr_i         (req_addr),
        .req_wdata_i        (req_wdata),
        .req_cmd_i          (req_cmd),
        .req_typ_i          (req_typ),
        .req_kill_i         (req_kill),
        .resp_valid_o       (resp_valid),
        .resp_data_o        (resp_data),
        .resp_xcpt_o        (resp_xcpt),
        .resp_err_o         (resp_err),
        .dmem_req_valid_o   (d_valid),
        .dmem_req_ready_i   (d_ready),
        .dmem_req_addr_o    (d_addr),
        .dmem_req_cmd_o     (d_cmd),
        .dmem_req_typ_o     (d_typ),
        .dmem_req_data_o    (d_data),
        .dmem_req_tag_o     (d_tag),
        .dmem_req_kill_o    (d_kill),
        .dmem_resp_valid_i  (r_valid),
        .dmem_resp_tag_i    (r_tag),
        .dmem_resp_data_i   (r_data),
        .dmem_resp_nack_i   (r_nack),
        .dmem_resp_replay_i (r_replay),
        .dmem_xcpt_ma_st_i  (x_ma_st),
        .dmem_xcpt_ma_ld_i  (x_ma_ld),
        .dmem_xcpt_pf_st_i  (x_pf_st),
        .dmem_xcpt_pf_ld_i  (x_pf_ld),
        .dmem_ordered_i     (ordered)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    // Present one op to the pipeline port for a single handshake cycle.
    task automatic issue(input logic [39:0] a, input logic [4:0] c, input logic [63:0] w);
        req_addr  = a;
        req_cmd   = c;
        req_wdata = w;
        req_typ   = 3'b011;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        logic ok;

        // Reset state
        tick();
        tick();
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_outs", {58'd0, resp_valid, resp_err, d_valid, d_kill, (|resp_xcpt), (|d_tag)}, 64'd0);
        rst = 1'b0;

        // Load, accepted immediately, response tag 0
        issue(40'h80001000, 5'b00000, 64'd0);
        chk("ld_req", {d_valid, req_ready, d_tag, d_addr}, {1'b1, 1'b0, 8'd0, 40'h80001000});
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        chk("ld_acc", {d_valid, d_tag}, {1'b0, 8'd1});
        tick();
        tick();
        chk("ld_noresp", {63'd0, resp_valid}, 64'd0);
        r_valid = 1'b1; r_tag = 8'd0; r_data = 64'hDEADBEEF;
        tick();
        r_valid = 1'b0;
        chk("ld_resp", {resp_valid, req_ready, resp_err, resp_xcpt}, {1'b1, 1'b1, 1'b0, 4'd0});
        chk("ld_data", resp_data, 64'hDEADBEEF);
        tick();
        chk("ld_pulse", {63'd0, resp_valid}, 64'd0);

        // Store, request stalled 5 cycles: payload and tag stable, then a single accept
        issue(40'h12345678, 5'b00001, 64'hCAFE);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (!(d_valid && d_addr == 40'h12345678 && d_tag == 8'd1 && d_data == 64'hCAFE
                  && d_cmd == 5'b00001 && d_typ == 3'b011)) ok = 1'b0;
            if (i == 5) d_ready = 1'b1;
            tick();
        end
        d_ready = 1'b0;
        chk("st_stable", {63'd0, ok}, 64'd1);
        chk("st_acc", {d_valid, d_tag}, {1'b0, 8'd2});
        r_valid = 1'b1; r_tag = 8'd1; r_data = 64'hFFFF;
        tick();
        r_valid = 1'b0;
        chk("st_resp", {resp_valid, resp_data}, {1'b1, 64'd0});

        // Two nacks then a response: tags 2, 3, 4; stale tag ignored
        d_ready = 1'b1;
        issue(40'h2000, 5'b00000, 64'd0);
        chk("nk_tag0", {d_valid, d_tag}, {1'b1, 8'd2});
        tick();
        r_nack = 1'b1;
        tick();
        r_nack = 1'b0;
        chk("nk_tag1", {d_valid, d_tag}, {1'b1, 8'd3});
        tick();
        r_valid = 1'b1; r_tag = 8'd2; r_data = 64'h111;
        tick();
        r_valid = 1'b0;
        chk("nk_stale", {62'd0, resp_valid, d_valid}, 64'd0);
        r_nack = 1'b1;
        tick();
        r_nack = 1'b0;
        chk("nk_tag2", {d_valid, d_tag, resp_valid}, {1'b1, 8'd4, 1'b0});
        tick();
        r_valid = 1'b1; r_tag = 8'd4; r_data = 64'hABCD;
        tick();
        r_valid = 1'b0;
        chk("nk_resp", {resp_valid, resp_err, resp_data}, {1'b1, 1'b0, 64'hABCD});

        // MAX_NACK+1 = 16 nacks: the 16th gives an error response
        issue(40'h3000, 5'b00000, 64'd0);
        ok = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick();
            r_nack = 1'b1;
            tick();
            r_nack = 1'b0;
            if (n < 15 && (resp_valid || !d_valid)) ok = 1'b0;
        end
        chk("nk_retries", {63'd0, ok}, 64'd1);
        chk("nk_err", {resp_valid, resp_err, d_valid, req_ready}, {1'b1, 1'b1, 1'b0, 1'b1});
        chk("nk_tagnext", {56'd0, d_tag}, 64'd21);

        // Kill in WAIT: kill pulse, late response discarded
        issue(40'h4000, 5'b00000, 64'd0);
        tick();
        d_ready = 1'b0;
        tick();
        req_kill = 1'b1;
        tick();
        req_kill = 1'b0;
        chk("kw_kill", {d_kill, resp_valid}, {1'b1, 1'b0});
        tick();
        chk("kw_pulse", {d_kill, req_ready}, {1'b0, 1'b0});
        r_valid = 1'b1; r_tag = 8'd21; r_data = 64'h5555;
        tick();
        r_valid = 1'b0;
        chk("kw_drop", {resp_valid, req_ready}, {1'b0, 1'b1});

        // Store with misaligned-store exception: no reissue
        d_ready = 1'b1;
        issue(40'h5001, 5'b00001, 64'h77);
        chk("xc_tag", {56'd0, d_tag}, 64'd22);
        tick();
        d_ready = 1'b0;
        x_ma_st = 1'b1;
        tick();
        x_ma_st = 1'b0;
        chk("xc_resp", {resp_valid, resp_xcpt, resp_data}, {1'b1, 4'b1000, 64'd0});
        tick();
        chk("xc_noretry", {d_valid, req_ready}, {1'b0, 1'b1});

        // Fence: ordered low for 10 cycles, response on cycle 11
        issue(40'h0, 5'b10100, 64'd0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (d_valid || resp_valid || req_ready) ok = 1'b0;
            tick();
        end
        chk("fn_wait", {63'd0, ok}, 64'd1);
        ordered = 1'b1;
        tick();
        ordered = 1'b0;
        chk("fn_resp", {resp_valid, resp_err, resp_data}, {1'b1, 1'b0, 64'd0});

        // Kill in REQ before accept: request dropped, no kill pulse
        issue(40'h6000, 5'b00000, 64'd0);
        req_kill = 1'b1;
        tick();
        req_kill = 1'b0;
        chk("kr_drop", {d_valid, d_kill, req_ready, resp_valid}, {1'b0, 1'b0, 1'b1, 1'b0});

        // Kill in the accept cycle: kill pulse, drain on nack, no response
        d_ready = 1'b1;
        issue(40'h7000, 5'b00000, 64'd0);
        req_kill = 1'b1;
        tick();
        req_kill = 1'b0;
        d_ready = 1'b0;
        chk("ka_kill", {d_kill, d_valid, d_tag}, {1'b1, 1'b0, 8'd24});
        r_nack = 1'b1;
        tick();
        r_nack = 1'b0;
        chk("ka_drain", {resp_valid, req_ready, d_valid}, {1'b0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
